// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the CPU request/response handshake and the word-wide
// memory bus of mem_ctrl. The slave modport is the controller. The master
// modport is its environment: the CPU side drives the request fields and the
// attached memory drives mem_rdata.
interface mem_ctrl_if;
  // CPU request / response
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  // Memory side
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rd;
  logic        mem_wr;

  modport master (
    output req, we, size, sext, addr, wdata, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport slave (
    input  req, we, size, sext, addr, wdata, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU-to-memory access controller for a word-wide asynchronous
// memory. Loads read one word; word stores write one word; sub-word stores
// read-modify-write the containing word. Illegal requests are rejected with
// err and never touch memory.
// Optional feature macro: MEM_CTRL_SUBWORD_EN enables byte/halfword loads and
// stores. Without it, byte and halfword requests are rejected as errors.
//
// Handshake: req is sampled only on a rising clock edge where ready=1 (IDLE);
// that edge accepts the request and latches we/size/sext/addr/wdata. A req
// seen while busy is dropped, never queued. done is a one-cycle pulse; err is
// valid with done, and rdata holds a load's result from its done until the
// next load's done.
module mem_ctrl #(
  parameter int MEM_BYTES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_WREL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // The last byte a word access could touch is addr+3; 33 bits keeps the sum
  // from wrapping near the top of the address space.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   bad;
  logic   we_q;

`ifdef MEM_CTRL_SUBWORD_EN
  logic [1:0]  size_q;
  logic        sext_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  // Selects the addressed byte/halfword lane of a memory word and extends it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sext);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   res = {{24{sext & sh[7]}}, sh[7:0]};
      2'b01:   res = {{16{sext & sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replaces the addressed byte/halfword lane of a memory word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic [31:0] data);
    logic [31:0] mask;
    logic [31:0] ins;
    mask = (size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << {lane, 3'b000};
    ins  = data << {lane, 3'b000};
    return (word & ~mask) | (ins & mask);
  endfunction
`else
  // Sign-extension control only matters for sub-word loads.
  logic unused_sext;
  assign unused_sext = bus.sext;
`endif

  assign accept    = (state == S_IDLE) && bus.req;
  assign dbg_state = state;

  // Classify the request on the bus as rejected (illegal size, misaligned,
  // or out of range).
  always_comb begin
    bad = (({1'b0, bus.addr} + 33'd3) >= MEM_LIMIT);
    case (bus.size)
      2'b10: if (bus.addr[1:0] != 2'b00) bad = 1'b1;
`ifdef MEM_CTRL_SUBWORD_EN
      2'b01: if (bus.addr[0]) bad = 1'b1;
      2'b00: bad = bad;
`else
      2'b00, 2'b01: bad = 1'b1;
`endif
      default: bad = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: loads and sub-word stores read first, word stores
  // write directly, rejected requests go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          if (bad)                                state_nxt = S_DONE;
          else if (!bus.we || bus.size != 2'b10)  state_nxt = S_RD;
          else                                    state_nxt = S_WR;
        end
      end
      S_RD:    state_nxt = we_q ? S_WR : S_DONE;
      S_WR:    state_nxt = S_WREL;
      S_WREL:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs decoded straight from the state register so the memory
  // strobes are glitch-free.
  always_comb begin
    bus.ready  = (state == S_IDLE);
    bus.done   = (state == S_DONE);
    bus.mem_rd = (state == S_RD);
    bus.mem_wr = (state == S_WR);
  end

  // Datapath: latch the request on accept; at the end of RD either deliver
  // the load result or build the merged store word. mem_addr/mem_wdata move
  // only at these two points, so they are stable through WR and WREL.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.err       <= 1'b0;
      bus.rdata     <= 32'h0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      we_q          <= 1'b0;
`ifdef MEM_CTRL_SUBWORD_EN
      size_q        <= 2'b00;
      sext_q        <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 32'h0;
`endif
    end else begin
      if (accept) begin
        bus.err       <= bad;
        we_q          <= bus.we;
        bus.mem_addr  <= {bus.addr[31:2], 2'b00};
        bus.mem_wdata <= bus.wdata;
`ifdef MEM_CTRL_SUBWORD_EN
        size_q        <= bus.size;
        sext_q        <= bus.sext;
        lane_q        <= bus.addr[1:0];
        wdata_q       <= bus.wdata;
`endif
      end
      if (state == S_RD) begin
`ifdef MEM_CTRL_SUBWORD_EN
        if (we_q) bus.mem_wdata <= store_merge(bus.mem_rdata, size_q, lane_q, wdata_q);
        else      bus.rdata     <= load_extract(bus.mem_rdata, size_q, lane_q, sext_q);
`else
        if (!we_q) bus.rdata <= bus.mem_rdata;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. Directed vectors from a
// struct table, hand-written reset-abort and held-request sequences, and a
// randomized phase checked against a byte-addressed reference memory.
// Works in both builds (MEM_CTRL_SUBWORD_EN defined or not).
module tb_mem_ctrl;

`ifdef MEM_CTRL_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif
  localparam int MEM_BYTES = 65536;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  mem_ctrl_if bus ();

  mem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model attached to the DUT ----------------
  logic [31:0] mem [0:16383];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  // Memory latches data on the rising edge of the write strobe.
  always @(posedge bus.mem_wr) begin
    mem[bus.mem_addr[15:2]] = bus.mem_wdata;
    wr_cnt++;
  end

  always @(posedge bus.mem_rd) rd_cnt++;

  always @(negedge clk) if (bus.done) done_cnt++;

  always_comb bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr[15:2]] : 32'h0;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one request for one cycle and waits (bounded) for done.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic e, output logic [31:0] rd,
                           output int nwr, output int nrd);
    int wr0;
    int rd0;
    @(negedge clk);
    check("ready_before_req", {31'b0, bus.ready}, 32'd1);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sext = sx; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    e   = bus.err;
    rd  = bus.rdata;
    nwr = wr_cnt - wr0;
    nrd = rd_cnt - rd0;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_bytes [0:65535];

  // Byte-addressed, little-endian view of memory; computes the outcome of an
  // access from the access rules and updates the reference memory.
  task automatic model(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic e, output int lat, output int nwr, output int nrd);
    int n;
    logic [31:0] v;
    e = 1'b0;
    if (sz == 2'd3) e = 1'b1;
    else if (!SUBWORD && sz != 2'd2) e = 1'b1;
    else if (sz == 2'd1 && a[0]) e = 1'b1;
    else if (sz == 2'd2 && a[1:0] != 2'd0) e = 1'b1;
    if (longint'(a) + 3 >= longint'(MEM_BYTES)) e = 1'b1;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    nwr = 0;
    nrd = 0;
    if (e) begin
      lat = 1;
    end else if (!w) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
      if (sx && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sx && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      exp_q.push_back(v);
      lat = 2;
      nrd = 1;
    end else begin
      for (int i = 0; i < n; i++) ref_bytes[a + i] = 8'(d >> (8 * i));
      lat = (n == 4) ? 3 : 4;
      nrd = (n == 4) ? 0 : 1;
      nwr = 1;
    end
  endtask

  task automatic model_and_check(input logic w, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] d);
    logic e_exp, e_act;
    int lat_exp, lat_act, nwr_exp, nwr_act, nrd_exp, nrd_act;
    logic [31:0] rd_act;
    logic [31:0] rd_exp;
    model(w, sz, sx, a, d, e_exp, lat_exp, nwr_exp, nrd_exp);
    do_access(w, sz, sx, a, d, lat_act, e_act, rd_act, nwr_act, nrd_act);
    check($sformatf("rnd_lat a=%08h sz=%0d we=%0d", a, sz, w), 32'(lat_act), 32'(lat_exp));
    check($sformatf("rnd_err a=%08h sz=%0d we=%0d", a, sz, w), {31'b0, e_act}, {31'b0, e_exp});
    check($sformatf("rnd_nwr a=%08h", a), 32'(nwr_act), 32'(nwr_exp));
    check($sformatf("rnd_nrd a=%08h", a), 32'(nrd_act), 32'(nrd_exp));
    if (!w && !e_exp) begin
      rd_exp = exp_q.pop_front();
      check($sformatf("rnd_rdata a=%08h sz=%0d sx=%0d", a, sz, sx), rd_act, rd_exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    logic [31:0] rdata;
    int          nwr;
    int          nrd;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic e, input int lat, input logic [31:0] rd,
                              input int nwr, input int nrd);
    vec_t v;
    v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = d;
    v.err = e; v.lat = lat; v.rdata = rd; v.nwr = nwr; v.nrd = nrd;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic e;
    logic [31:0] rd;
    int nwr, nrd, wr0, d0;
    logic [31:0] a, wexp;
    logic [1:0] sz;

    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.sext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;

    vecs.push_back(mk(1, 2'd2, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 3, 32'h0,         1, 0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h0000_0010, 32'h0,        0, 2, 32'hDEAD_BEEF, 0, 1));
    vecs.push_back(mk(1, 2'd2, 0, 32'h0000_FFFC, 32'hCAFE_F00D, 0, 3, 32'h0,        1, 0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h0000_FFFC, 32'h0,        0, 2, 32'hCAFE_F00D, 0, 1));
    vecs.push_back(mk(0, 2'd2, 0, 32'h0000_0013, 32'h0,        1, 1, 32'h0,         0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 32'h0000_0011, 32'h1234,     1, 1, 32'h0,         0, 0));
    vecs.push_back(mk(0, 2'd0, 0, 32'h0000_FFFD, 32'h0,        1, 1, 32'h0,         0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 32'h0001_0000, 32'h1,        1, 1, 32'h0,         0, 0));
    vecs.push_back(mk(0, 2'd3, 0, 32'h0000_0020, 32'h0,        1, 1, 32'h0,         0, 0));
    vecs.push_back(mk(1, 2'd3, 0, 32'h0000_0020, 32'h5,        1, 1, 32'h0,         0, 0));
    if (SUBWORD) begin
      vecs.push_back(mk(1, 2'd2, 0, 32'h0000_0010, 32'h1122_3344, 0, 3, 32'h0,         1, 0));
      vecs.push_back(mk(1, 2'd0, 0, 32'h0000_0012, 32'hFFFF_FFAA, 0, 4, 32'h0,         1, 1));
      vecs.push_back(mk(0, 2'd2, 0, 32'h0000_0010, 32'h0,         0, 2, 32'h11AA_3344, 0, 1));
      vecs.push_back(mk(1, 2'd2, 0, 32'h0000_0020, 32'h80F0_7F01, 0, 3, 32'h0,         1, 0));
      vecs.push_back(mk(0, 2'd0, 1, 32'h0000_0021, 32'h0,         0, 2, 32'h0000_007F, 0, 1));
      vecs.push_back(mk(0, 2'd0, 1, 32'h0000_0022, 32'h0,         0, 2, 32'hFFFF_FFF0, 0, 1));
      vecs.push_back(mk(0, 2'd1, 0, 32'h0000_0022, 32'h0,         0, 2, 32'h0000_80F0, 0, 1));
      vecs.push_back(mk(0, 2'd1, 1, 32'h0000_0022, 32'h0,         0, 2, 32'hFFFF_80F0, 0, 1));
      vecs.push_back(mk(1, 2'd1, 0, 32'h0000_0022, 32'hABCD_1234, 0, 4, 32'h0,         1, 1));
      vecs.push_back(mk(0, 2'd2, 0, 32'h0000_0020, 32'h0,         0, 2, 32'h1234_7F01, 0, 1));
      vecs.push_back(mk(0, 2'd0, 0, 32'h0000_0023, 32'h0,         0, 2, 32'h0000_0012, 0, 1));
      vecs.push_back(mk(0, 2'd0, 0, 32'h0000_FFFC, 32'h0,         0, 2, 32'h0000_000D, 0, 1));
    end else begin
      vecs.push_back(mk(0, 2'd0, 0, 32'h0000_0010, 32'h0,         1, 1, 32'h0,         0, 0));
      vecs.push_back(mk(1, 2'd0, 0, 32'h0000_0012, 32'hAA,        1, 1, 32'h0,         0, 0));
      vecs.push_back(mk(0, 2'd1, 1, 32'h0000_0010, 32'h0,         1, 1, 32'h0,         0, 0));
      vecs.push_back(mk(0, 2'd2, 0, 32'h0000_0010, 32'h0,         0, 2, 32'hDEAD_BEEF, 0, 1));
    end

    // Reset values, sampled while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     {31'b0, bus.ready},  32'd1);
    check("rst_done",      {31'b0, bus.done},   32'd0);
    check("rst_err",       {31'b0, bus.err},    32'd0);
    check("rst_rdata",     bus.rdata,           32'h0);
    check("rst_mem_rd",    {31'b0, bus.mem_rd}, 32'd0);
    check("rst_mem_wr",    {31'b0, bus.mem_wr}, 32'd0);
    check("rst_mem_addr",  bus.mem_addr,        32'h0);
    check("rst_mem_wdata", bus.mem_wdata,       32'h0);
    reset = 1'b0;

    // Table-driven directed vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      do_access(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                lat, e, rd, nwr, nrd);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].err});
      check($sformatf("vec%0d_nwr", i), 32'(nwr), 32'(vecs[i].nwr));
      check($sformatf("vec%0d_nrd", i), 32'(nrd), 32'(vecs[i].nrd));
      if (!vecs[i].we && !vecs[i].err)
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
    end
    if (SUBWORD) check("sub_store_word", mem[32'h10 >> 2], 32'h11AA_3344);

    // Reset during WREL: aborts without done; the write already strobed stays.
    @(negedge clk);
    d0 = done_cnt;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.sext = 1'b0;
    bus.addr = 32'h0000_0040; bus.wdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    check("abort_wr_strobe", {31'b0, bus.mem_wr}, 32'd1);
    @(negedge clk);
    check("abort_wrel_low",  {31'b0, bus.mem_wr}, 32'd0);
    check("abort_wrel_addr", bus.mem_addr,  32'h0000_0040);
    check("abort_wrel_data", bus.mem_wdata, 32'h5555_AAAA);
    reset = 1'b1;
    @(negedge clk);
    check("abort_idle",  {31'b0, bus.ready}, 32'd1);
    check("abort_done0", {31'b0, bus.done},  32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_write_kept", mem[32'h40 >> 2], 32'h5555_AAAA);

    // req held high through the whole access: exactly one access happens, and
    // the memory address/data do not move while the write is in flight.
    @(negedge clk);
    wr0 = wr_cnt;
    d0  = done_cnt;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.sext = 1'b0;
    bus.addr = 32'h0000_0044; bus.wdata = 32'h0BAD_F00D;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.mem_wr) begin
        check("held_wr_addr", bus.mem_addr,  32'h0000_0044);
        check("held_wr_data", bus.mem_wdata, 32'h0BAD_F00D);
      end
      if (bus.done) break;
    end
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    check("held_one_write", 32'(wr_cnt - wr0), 32'd1);
    check("held_one_done",  32'(done_cnt - d0), 32'd1);
    check("held_mem_word",  mem[32'h44 >> 2], 32'h0BAD_F00D);

    // Randomized phase: seed the tracked windows through word stores, then
    // random accesses checked against the reference model.
    for (int w = 0; w < 16; w++) model_and_check(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * w), $urandom);
    for (int w = 0; w < 4; w++)  model_and_check(1'b1, 2'd2, 1'b0, 32'hFFF0 + 32'(4 * w), $urandom);
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        7, 8:    a = 32'hFFF0 + 32'($urandom_range(0, 15));
        9:       a = 32'h0001_0000 | $urandom;
        default: a = 32'h100 + 32'($urandom_range(0, 63));
      endcase
      sz = 2'($urandom_range(0, 3));
      model_and_check(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Final memory contents of the tracked windows.
    for (int w = 0; w < 20; w++) begin
      a = (w < 16) ? 32'h100 + 32'(4 * w) : 32'hFFF0 + 32'(4 * (w - 16));
      wexp = {ref_bytes[a + 3], ref_bytes[a + 2], ref_bytes[a + 1], ref_bytes[a]};
      check($sformatf("final_mem_%08h", a), mem[a[15:2]], wexp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: MEM_BYTES, default 65536, byte capacity of attached memory; any access with addr+3 >= MEM_BYTES is out of range.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  1  CPU access request, sampled only while ready=1.
REQ-005 we  in  1  1=store, 0=load.
REQ-006 size  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-007 sext  in  1  loads only: 1=sign-extend, 0=zero-extend sub-word data.
REQ-008 addr  in  32  CPU byte address.
REQ-009 wdata  in  32  store data, right-aligned for sub-word sizes.
REQ-010 ready  out  1  high only in IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with done; 1 = rejected, no memory write performed.
REQ-013 rdata  out  32  load result, valid from done until next load's done.
REQ-014 mem_addr  out  32  word address to memory, always {addr[31:2],2'b00}.
REQ-015 mem_wdata  out  32  full word to memory.
REQ-016 mem_rdata  in  32  word from memory (valid 1 time unit after mem_rd rises).
REQ-017 mem_rd  out  1  memory output enable.
REQ-018 mem_wr  out  1  memory write strobe; memory writes on its rising edge.

Function
REQ-019 States: IDLE, RD, WR, WREL, DONE; mem_rd=1 only in RD, mem_wr=1 only in WR, both decoded from state register.
REQ-020 IDLE + req: latch we/size/sext/addr/wdata; error (size=11, halfword addr[0]=1, word addr[1:0]!=0, out of range) -> DONE with err=1; load or sub-word store -> RD; word store -> WR.
REQ-021 RD lasts one cycle; mem_rdata captured at its closing edge; then load -> DONE, store -> WR.
REQ-022 Load result: byte lane addr[1:0], halfword lane addr[1]; extended per sext; word passed unchanged.
REQ-023 Sub-word store: captured word with selected byte/halfword lane replaced by wdata[7:0]/wdata[15:0]; other bytes unchanged.
REQ-024 WR one cycle (mem_wr=1), then WREL one cycle (mem_wr=0) with mem_addr/mem_wdata held stable; WREL -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; req during RD/WR/WREL/DONE ignored and not queued.
REQ-026 Latency from accepting edge to done high: error 1 cycle, load 2, word store 3, sub-word store 4.
REQ-027 mem_addr/mem_wdata change only on accept and on RD exit; never while mem_wr=1 or in WREL.

Reset
REQ-028 reset: state=IDLE, ready=1, done=0, err=0, rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset mid-operation aborts without done; a write whose mem_wr edge already occurred is not undone.

Configuration
REQ-030 MEM_CTRL_SUBWORD_EN defined: byte/halfword loads and stores per REQ-020..023.
REQ-031 MEM_CTRL_SUBWORD_EN undefined: size 00/01 rejected as error (done, err=1, no memory access); word behaviour unchanged.

Verification
REQ-032 Word store addr=0x10 wdata=0xDEADBEEF, then word load addr=0x10 -> done at +3 and +2, rdata=0xDEADBEEF, err=0.
REQ-033 Memory word 0x10=0x11223344, byte store addr=0x12 wdata=0xAA -> word 0x10=0x11AA3344, done at +4, one mem_wr pulse.
REQ-034 Word 0x20=0x80F07F01, loads: byte 0x21 sext=1 -> 0x0000007F; byte 0x22 sext=1 -> 0xFFFFFFF0; half 0x22 sext=0 -> 0x000080F0.
REQ-035 Word load addr=0x13, half store addr=0x11, addr=0xFFFD, size=11 -> each done at +1 with err=1, mem_rd and mem_wr never asserted.
REQ-036 reset asserted during WREL -> next cycle IDLE, no done; req held high during busy -> exactly one access performed.
REQ-037 Build without MEM_CTRL_SUBWORD_EN: byte load addr=0x10 -> err=1 at +1; word load still correct.
